// File: rtl/dense_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dense_seq_ctrl_pkg
// Description : Shared settle latencies, state encoding and helpers for the
//               dense-layer chain sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dense_seq_ctrl_pkg;

    // Default settle cycles for each dense layer
    localparam int LAT_1 = 64;
    localparam int LAT_2 = 64;
    localparam int LAT_3 = 32;

    // Default settle counter width; must hold max(LAT_n)-1
    localparam int CNT_W = 8;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN_L1 = 3'd1,
        CAP_L1 = 3'd2,
        RUN_L2 = 3'd3,
        CAP_L2 = 3'd4,
        RUN_L3 = 3'd5,
        CAP_L3 = 3'd6,
        DONE   = 3'd7
    } seq_state_t;

    // Layer index (1..3) to one-hot enable; index 0 means no layer active
    function automatic logic [2:0] layer_onehot(input logic [1:0] idx);
        logic [2:0] v;
        v = 3'b000;
        case (idx)
            2'd1:    v = 3'b001;
            2'd2:    v = 3'b010;
            2'd3:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dense_seq_ctrl_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_settle_counter
// Description : Loadable down-counter that measures a layer's settle time.
//               Decrement saturates at zero so the count never wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_settle_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    // Count register: clear, load on entering a RUN state, else saturating decrement
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/dense_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dense_seq_ctrl
// Description : Sequencer for the three-layer dense chain. Enables one layer
//               at a time for its settle time, strobes a capture after each
//               layer and offers the final result with a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dense_seq_ctrl #(
    parameter int LAT_1 = dense_seq_ctrl_pkg::LAT_1,
    parameter int LAT_2 = dense_seq_ctrl_pkg::LAT_2,
    parameter int LAT_3 = dense_seq_ctrl_pkg::LAT_3,
    parameter int CNT_W = dense_seq_ctrl_pkg::CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       out_ack,
    output logic       busy,
    output logic [2:0] layer_en,
    output logic [2:0] capture,
    output logic [1:0] layer_idx,
    output logic       out_valid,
    output logic       err_start
);

    import dense_seq_ctrl_pkg::*;

    // Counter reload values: RUN_Ln lasts LAT_n cycles (count LAT_n-1 down to 0)
    localparam logic [CNT_W-1:0] c_LOAD_L1 = CNT_W'(LAT_1 - 1);
    localparam logic [CNT_W-1:0] c_LOAD_L2 = CNT_W'(LAT_2 - 1);
    localparam logic [CNT_W-1:0] c_LOAD_L3 = CNT_W'(LAT_3 - 1);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic             r_err_start;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_clr;
    logic             w_zero;
    logic             w_not_idle;

    assign w_not_idle = (r_state != IDLE);

    // Abort wipes the count so an aborted pass leaves nothing behind
    assign w_clr = abort && w_not_idle;

    // Only RUN states consume settle time
    assign w_dec = (r_state == RUN_L1) || (r_state == RUN_L2) || (r_state == RUN_L3);

    seq_settle_counter #(
        .CNT_W (CNT_W)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky flag for a start request arriving while a pass is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_start <= 1'b0;
        end else if (start && w_not_idle) begin
            r_err_start <= 1'b1;
        end
    end

    // Next-state logic and counter load control; abort outranks everything
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        if (abort && w_not_idle) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_next     = RUN_L1;
                        w_load     = 1'b1;
                        w_load_val = c_LOAD_L1;
                    end
                end
                RUN_L1: if (w_zero) w_next = CAP_L1;
                CAP_L1: begin
                    w_next     = RUN_L2;
                    w_load     = 1'b1;
                    w_load_val = c_LOAD_L2;
                end
                RUN_L2: if (w_zero) w_next = CAP_L2;
                CAP_L2: begin
                    w_next     = RUN_L3;
                    w_load     = 1'b1;
                    w_load_val = c_LOAD_L3;
                end
                RUN_L3: if (w_zero) w_next = CAP_L3;
                CAP_L3: w_next = DONE;
                DONE:   if (out_ack) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Moore output decode from the registered state
    always_comb begin
        busy      = 1'b0;
        layer_idx = 2'd0;
        capture   = 3'b000;
        out_valid = 1'b0;
        case (r_state)
            RUN_L1, CAP_L1: begin
                busy      = 1'b1;
                layer_idx = 2'd1;
            end
            RUN_L2, CAP_L2: begin
                busy      = 1'b1;
                layer_idx = 2'd2;
            end
            RUN_L3, CAP_L3: begin
                busy      = 1'b1;
                layer_idx = 2'd3;
            end
            DONE:    out_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
        layer_en = layer_onehot(layer_idx);
        if ((r_state == CAP_L1) || (r_state == CAP_L2) || (r_state == CAP_L3)) begin
            capture = layer_en;
        end
    end

    assign err_start = r_err_start;

endmodule
`default_nettype wire

// File: tb/tb_dense_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dense_seq_ctrl
// Description : Directed self-checking bench for dense_seq_ctrl. Expected
//               outputs follow the cycle numbering where start is sampled at
//               edge 0 and cycle k is the state seen after edge k-1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dense_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start0, abort0, out_ack0;
    logic       start1, abort1, out_ack1;
    logic       busy0, out_valid0, err0;
    logic       busy1, out_valid1, err1;
    logic [2:0] layer_en0, capture0, layer_en1, capture1;
    logic [1:0] layer_idx0, layer_idx1;
    logic [9:0] w_obs0, w_obs1;

    int n_chk;
    int n_pass;
    int cyc;

    dense_seq_ctrl u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start0),
        .abort     (abort0),
        .out_ack   (out_ack0),
        .busy      (busy0),
        .layer_en  (layer_en0),
        .capture   (capture0),
        .layer_idx (layer_idx0),
        .out_valid (out_valid0),
        .err_start (err0)
    );

    dense_seq_ctrl #(
        .LAT_1 (1),
        .LAT_2 (1),
        .LAT_3 (1),
        .CNT_W (8)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .abort     (abort1),
        .out_ack   (out_ack1),
        .busy      (busy1),
        .layer_en  (layer_en1),
        .capture   (capture1),
        .layer_idx (layer_idx1),
        .out_valid (out_valid1),
        .err_start (err1)
    );

    assign w_obs0 = {busy0, layer_en0, capture0, layer_idx0, out_valid0};
    assign w_obs1 = {busy1, layer_en1, capture1, layer_idx1, out_valid1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observation, count it and report a mismatch
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance to cycle k, sampling 1 time unit after the active edge
    task automatic to_cycle(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Expected {busy, layer_en, capture, layer_idx, out_valid} at cycle c;
    // ack_c is the cycle whose edge takes the acknowledge (IDLE afterwards)
    function automatic logic [9:0] exp_vec(input int c, input int l1, input int l2,
                                           input int l3, input int ack_c);
        logic [9:0] v;
        v = 10'd0;
        if (c < 1 || c > ack_c)                 v = 10'd0;
        else if (c <= l1)                       v = {1'b1, 3'b001, 3'b000, 2'd1, 1'b0};
        else if (c == l1 + 1)                   v = {1'b1, 3'b001, 3'b001, 2'd1, 1'b0};
        else if (c <= l1 + l2 + 1)              v = {1'b1, 3'b010, 3'b000, 2'd2, 1'b0};
        else if (c == l1 + l2 + 2)              v = {1'b1, 3'b010, 3'b010, 2'd2, 1'b0};
        else if (c <= l1 + l2 + l3 + 2)         v = {1'b1, 3'b100, 3'b000, 2'd3, 1'b0};
        else if (c == l1 + l2 + l3 + 3)         v = {1'b1, 3'b100, 3'b100, 2'd3, 1'b0};
        else                                    v = {1'b0, 3'b000, 3'b000, 2'd0, 1'b1};
        return v;
    endfunction

    // Pulse start for one edge; that edge becomes edge 0 of the new pass
    task automatic launch0();
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        cyc = 1;
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        cyc      = 0;
        rst      = 1'b1;
        start0   = 1'b0; abort0 = 1'b0; out_ack0 = 1'b0;
        start1   = 1'b0; abort1 = 1'b0; out_ack1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs0", 32'(w_obs0), 32'd0);
        chk("reset_err0",  32'(err0),   32'd0);
        chk("reset_outs1", 32'(w_obs1), 32'd0);
        rst = 1'b0;

        // Pass A: defaults, stray start at cycle 10, ack delayed 20 cycles,
        // then start and ack together in DONE
        launch0();
        chk("A_err_c1", 32'(err0), 32'd0);
        for (int c = 1; c <= 185; c++) begin
            to_cycle(c);
            chk($sformatf("A_c%0d", c), 32'(w_obs0), 32'(exp_vec(c, 64, 64, 32, 184)));
            if (c == 11 || c == 185) chk($sformatf("A_err_c%0d", c), 32'(err0), 32'd1);
            start0   = (c == 10) || (c == 184);
            out_ack0 = (c == 184);
        end
        start0   = 1'b0;
        out_ack0 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("A_err_after_rst", 32'(err0), 32'd0);

        // Pass B: abort during RUN_L2 at cycle 70
        launch0();
        for (int c = 1; c <= 75; c++) begin
            to_cycle(c);
            chk($sformatf("B_c%0d", c), 32'(w_obs0),
                (c <= 70) ? 32'(exp_vec(c, 64, 64, 32, 1000)) : 32'd0);
            abort0 = (c == 70);
            start0 = (c == 75);
        end
        abort0 = 1'b0;

        // Pass C: nominal timing after abort; ack at 164, immediate restart
        @(posedge clk);
        #1;
        start0 = 1'b0;
        cyc = 1;
        for (int c = 1; c <= 165; c++) begin
            to_cycle(c);
            chk($sformatf("C_c%0d", c), 32'(w_obs0), 32'(exp_vec(c, 64, 64, 32, 164)));
            out_ack0 = (c == 164);
            start0   = (c == 165);
        end
        out_ack0 = 1'b0;
        chk("C_err", 32'(err0), 32'd0);

        // Pass D: back-to-back start, rst pulse during cycle 150
        @(posedge clk);
        #1;
        start0 = 1'b0;
        cyc = 1;
        for (int c = 1; c <= 170; c++) begin
            to_cycle(c);
            chk($sformatf("D_c%0d", c), 32'(w_obs0),
                (c <= 150) ? 32'(exp_vec(c, 64, 64, 32, 1000)) : 32'd0);
            rst = (c == 150);
        end
        rst = 1'b0;

        // Pass E: all settle times of one cycle
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        cyc = 1;
        for (int c = 1; c <= 9; c++) begin
            to_cycle(c);
            chk($sformatf("E_c%0d", c), 32'(w_obs1), 32'(exp_vec(c, 1, 1, 1, 8)));
            out_ack1 = (c == 8);
        end
        out_ack1 = 1'b0;
        chk("E_err", 32'(err1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dense_seq_ctrl.md
# dense_seq_ctrl

Sequencer for the dense-layer chain (dense_layer_1 → dense_layer_2 → dense_layer_3). It enables one layer at a time and holds it enabled for a parameterised settle time. After each layer it pulses a capture strobe so the datapath registers that layer's output vector as the next layer's input. It presents the final 32-element result with a valid/ack handshake to the classifier stage.

## Interface
- LAT_1, default 64: settle cycles for dense_layer_1 (≥1)
- LAT_2, default 64: settle cycles for dense_layer_2 (≥1)
- LAT_3, default 32: settle cycles for dense_layer_3 (≥1)
- CNT_W, default 8: settle counter width; must hold max(LAT_n)-1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one inference pass; sampled only in IDLE
- abort  in  1  cancel pass; return to IDLE next edge
- out_ack  in  1  consumer has taken result
- busy  out  1  high in any RUN/CAP state
- layer_en  out  3  one-hot layer enable; bit n-1 = dense_layer_n
- capture  out  3  one-cycle strobe; bit n-1 = latch dense_layer_n output
- layer_idx  out  2  0 idle/done, 1..3 = active layer
- out_valid  out  1  final vector stable and owned by consumer
- err_start  out  1  sticky: start seen while not IDLE; cleared by rst

## Operation
- States: IDLE, RUN_L1, CAP_L1, RUN_L2, CAP_L2, RUN_L3, CAP_L3, DONE.
- IDLE: start=1 → RUN_L1; counter loaded with LAT_1-1.
- RUN_Ln: layer_en = one-hot n; counter decrements each cycle; at counter==0 → CAP_Ln.
- CAP_Ln: layer_en stays one-hot n; capture[n-1]=1 for exactly this cycle.
  - CAP_L1 → RUN_L2, counter loaded with LAT_2-1.
  - CAP_L2 → RUN_L3, counter loaded with LAT_3-1.
  - CAP_L3 → DONE.
- DONE: out_valid=1, layer_en=000, held until out_ack=1 → IDLE.
- abort=1 in any state other than IDLE → IDLE next edge, with all outputs at reset values. No capture is issued on that edge. abort has priority over start, out_ack and counter expiry.
- start while not IDLE: ignored; sets err_start. In DONE, if start and out_ack arrive together, go to IDLE; start is ignored and err_start is set.
- Counter: CNT_W unsigned, loaded only on entering RUN_Ln, never wraps (decrement gated at 0).
- LAT_n=1: RUN_Ln lasts exactly one cycle.

## Timing
- Reset values: state IDLE, busy 0, layer_en 000, capture 000, layer_idx 0, out_valid 0, err_start 0, counter 0.
- rst mid-pass: same as abort plus clearing err_start; reset takes precedence over all inputs.
- Edge numbering: start sampled high at edge 0.
  - RUN_L1 occupies cycles 1..LAT_1; CAP_L1 is cycle LAT_1+1.
  - RUN_L2 starts at cycle LAT_1+2.
  - CAP_L3 is cycle LAT_1+LAT_2+LAT_3+3.
  - out_valid first high at cycle LAT_1+LAT_2+LAT_3+4 (164 with defaults).
- All outputs are registered-state decodes (Moore); no combinational input-to-output path.
- out_ack sampled only in DONE; out_valid drops the cycle after the out_ack edge.
- Back-to-back: a new start is accepted the cycle after returning to IDLE.

## Structure
- nn_parameters gains LAT_1/LAT_2/LAT_3 localparams and a seq_state_t enum. The block's parameter defaults reference them.
- One sub-module is natural: seq_settle_counter (load/decrement/zero flag, CNT_W wide).
- The FSM and the output decode live in dense_seq_ctrl. No datapath vectors pass through this block.

## Test plan
- Reset then start pulse, defaults:
  - layer_en = 001 for cycles 1–64, then 010, then 100.
  - capture strobes at cycles 65, 130, 163.
  - out_valid rises at cycle 164 and holds until out_ack.
- LAT_1=LAT_2=LAT_3=1: full pass with capture at cycles 2, 4, 6 and out_valid at cycle 7.
- abort at cycle 70 (RUN_L2): IDLE at cycle 71, no capture[1] ever, all outputs at reset values; the next start gives nominal timing.
- start asserted at cycle 10: ignored, err_start = 1 and sticky, pass timing unchanged. rst clears err_start.
- out_ack held low for 20 cycles in DONE: out_valid stays high, layer_en stays 000. With start and out_ack together, the block goes to IDLE and err_start = 1.
- rst pulse at cycle 150: all outputs at reset values the next cycle; no capture[2] and no out_valid afterwards.
